// File: rtl/pkt_queue_mc.sv
// pkt_queue_mc: per-channel circular packet FIFOs feeding one
// registered output port through a round-robin arbiter.
module pkt_queue_mc #(
    parameter int NUM_CH    = 4,
    parameter int DEPTH     = 16,
    parameter int ID_W      = 32,
    parameter int ADDR_W    = 128,
    parameter int PAYLOAD_W = 128,
    parameter int AFULL_LVL = 14,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH_W-1:0]      in_ch,
    input  logic [ID_W-1:0]      in_id,
    input  logic [ADDR_W-1:0]    in_src,
    input  logic [ADDR_W-1:0]    in_dest,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH_W-1:0]      out_ch,
    output logic [ID_W-1:0]      out_id,
    output logic [ADDR_W-1:0]    out_src,
    output logic [ADDR_W-1:0]    out_dest,
    output logic [PAYLOAD_W-1:0] out_payload,
    input  logic [NUM_CH-1:0]    flush,
    output logic [NUM_CH-1:0]    ch_empty,
    output logic [NUM_CH-1:0]    ch_full,
    output logic [NUM_CH-1:0]    ch_afull
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PKT_W = ID_W + 2 * ADDR_W + PAYLOAD_W;

    logic [PKT_W-1:0]  mem_q [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [CNT_W-1:0]  count_d  [NUM_CH];
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [PKT_W-1:0]  out_pkt_q, out_pkt_d;

    logic [NUM_CH-1:0] in_sel;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] eligible;
    logic              grant_found;
    logic [CH_W-1:0]   grant;
    logic              load;
    logic [PKT_W-1:0]  head_pkt;

    // channel index a+b, wrapped modulo NUM_CH (b < NUM_CH)
    function automatic logic [CH_W-1:0] wrap_add(
        input logic [CH_W-1:0] a,
        input int              b
    );
        int s;
        s = int'(a) + b;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

    // status flags straight from the registered counts
    always_comb begin
        ch_empty = '0;
        ch_full  = '0;
        ch_afull = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_empty[c] = (count_q[c] == '0);
            ch_full[c]  = (count_q[c] == CNT_W'(DEPTH));
            ch_afull[c] = (count_q[c] >= CNT_W'(AFULL_LVL));
        end
    end

    // input decode; an out-of-range channel matches no select bit
    always_comb begin
        in_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            in_sel[c] = (in_ch == CH_W'(c));
        end
        in_ready = |(in_sel & ~ch_full & ~flush);
        push     = (in_valid && in_ready) ? in_sel : '0;
    end

    // round-robin pick of the first non-empty, non-flushed channel
    always_comb begin
        eligible    = ~ch_empty & ~flush;
        grant_found = 1'b0;
        grant       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_found && eligible[wrap_add(rr_ptr_q, i)]) begin
                grant_found = 1'b1;
                grant       = wrap_add(rr_ptr_q, i);
            end
        end
        load     = (!out_valid_q || out_ready) && grant_found;
        pop      = '0;
        if (load) pop[grant] = 1'b1;
        rr_ptr_d = load ? wrap_add(grant, 1) : rr_ptr_q;
        head_pkt = mem_q[grant][rd_ptr_q[grant]];
    end

    // per-channel pointer and count update; flush wins over everything
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(push[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(pop[c]);
            count_d[c]  = count_q[c] + CNT_W'(push[c])
                          - CNT_W'(pop[c]);
            if (flush[c]) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                count_d[c]  = '0;
            end
        end
    end

    // output register: reload on grant, drop valid when drained dry
    always_comb begin
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_pkt_d   = out_pkt_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_ch_d    = grant;
            out_pkt_d   = head_pkt;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '{default: '0};
            rd_ptr_q    <= '{default: '0};
            count_q     <= '{default: '0};
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_pkt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_pkt_q   <= out_pkt_d;
        end
    end

    // packet storage, written on push, never reset
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
                mem_q[c][wr_ptr_q[c]] <=
                    {in_id, in_src, in_dest, in_payload};
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign {out_id, out_src, out_dest, out_payload} = out_pkt_q;

endmodule

// File: tb/tb_pkt_queue_mc.sv
// tb_pkt_queue_mc: directed test of pkt_queue_mc with
// hand-computed expected packet order and status flags.
module tb_pkt_queue_mc;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_ch;
    logic [31:0]  in_id;
    logic [127:0] in_src;
    logic [127:0] in_dest;
    logic [127:0] in_payload;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_ch;
    logic [31:0]  out_id;
    logic [127:0] out_src;
    logic [127:0] out_dest;
    logic [127:0] out_payload;
    logic [3:0]   flush;
    logic [3:0]   ch_empty;
    logic [3:0]   ch_full;
    logic [3:0]   ch_afull;

    int checks = 0;
    int errors = 0;

    pkt_queue_mc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ch      (in_ch),
        .in_id      (in_id),
        .in_src     (in_src),
        .in_dest    (in_dest),
        .in_payload (in_payload),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_id     (out_id),
        .out_src    (out_src),
        .out_dest   (out_dest),
        .out_payload(out_payload),
        .flush      (flush),
        .ch_empty   (ch_empty),
        .ch_full    (ch_full),
        .ch_afull   (ch_afull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v,
                         input logic [1:0] ch,
                         input logic [31:0] id);
        in_valid   = v;
        in_ch      = ch;
        in_id      = id;
        in_src     = {96'd0, id} + 128'h1000;
        in_dest    = {96'd0, id} + 128'h2000;
        in_payload = {4{id}};
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nin;
        int nout;
        int ex;
        logic acc;
        logic [1:0] seq [9];
        seq = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

        rst_n     = 1'b0;
        out_ready = 1'b0;
        flush     = '0;
        offer(1'b0, 2'd0, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        offer(1'b0, 2'd0, 32'd0);
        chk("rst_empty", ch_empty, 4'b1111);
        chk("rst_full", ch_full, 4'b0000);
        chk("rst_afull", ch_afull, 4'b0000);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_id", out_id, 32'd0);
        chk("rst_rdy", in_ready, 1'b1);

        // single packet to ch2
        out_ready = 1'b1;
        offer(1'b1, 2'd2, 32'h11);
        chk("sp_rdy", in_ready, 1'b1);
        tick;
        offer(1'b0, 2'd0, 32'd0);
        chk("sp_val0", out_valid, 1'b0);
        chk("sp_emp0", ch_empty, 4'b1011);
        tick;
        chk("sp_val1", out_valid, 1'b1);
        chk("sp_ch", out_ch, 2'd2);
        chk("sp_id", out_id, 32'h11);
        chk("sp_src", out_src, 128'h1011);
        chk("sp_pay", out_payload, {4{32'h11}});
        chk("sp_emp1", ch_empty, 4'b1111);
        tick;
        chk("sp_val2", out_valid, 1'b0);
        chk("sp_emp2", ch_empty, 4'b1111);

        // fill ch0 with the consumer stalled
        out_ready = 1'b0;
        for (int k = 0; k < 18; k++) begin
            offer(1'b1, 2'd0, 32'(k));
            chk("fill_rdy", in_ready, k <= 16);
            tick;
            chk("fill_afull", ch_afull[0], k >= 14);
            chk("fill_full", ch_full[0], k >= 16);
        end

        // drain while pushing 20 more; ids 0..36 in order
        out_ready = 1'b1;
        nin  = 17;
        nout = 0;
        for (int cyc = 0; cyc < 100 && nout < 37; cyc++) begin
            if (nin <= 36) offer(1'b1, 2'd0, 32'(nin));
            else offer(1'b0, 2'd0, 32'd0);
            acc = in_valid && in_ready;
            if (out_valid) begin
                chk("drain_id", out_id, 32'(nout));
                nout++;
            end
            tick;
            if (acc) nin++;
        end
        offer(1'b0, 2'd0, 32'd0);
        chk("drain_cnt", nout, 37);
        chk("drain_val", out_valid, 1'b0);
        chk("drain_emp", ch_empty, 4'b1111);

        // round robin across ch0, ch1, ch3
        out_ready = 1'b0;
        foreach (seq[i]) begin
            if (i < 3) begin
                for (int n = 0; n < 3; n++) begin
                    offer(1'b1, seq[i], 32'(seq[i]) * 16 + 32'(n));
                    tick;
                end
            end
        end
        offer(1'b0, 2'd0, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("rr_val", out_valid, 1'b1);
            chk("rr_ch", out_ch, seq[i]);
            chk("rr_id", out_id, 32'(seq[i]) * 16 + 32'(i / 3));
            tick;
        end
        chk("rr_end", out_valid, 1'b0);

        // ch1 held at count 8 while pushing and popping each cycle
        out_ready = 1'b0;
        for (int n = 0; n < 9; n++) begin
            offer(1'b1, 2'd1, 32'(100 + n));
            tick;
        end
        out_ready = 1'b1;
        ex = 100;
        for (int n = 0; n < 10; n++) begin
            offer(1'b1, 2'd1, 32'(109 + n));
            chk("ss_rdy", in_ready, 1'b1);
            chk("ss_val", out_valid, 1'b1);
            chk("ss_id", out_id, 32'(ex));
            ex++;
            tick;
        end
        offer(1'b0, 2'd0, 32'd0);
        for (int n = 0; n < 9; n++) begin
            chk("ss_dval", out_valid, 1'b1);
            chk("ss_did", out_id, 32'(ex));
            ex++;
            tick;
        end
        chk("ss_end", out_valid, 1'b0);

        // flush ch1 while ch0 drains
        out_ready = 1'b0;
        for (int n = 0; n < 6; n++) begin
            offer(1'b1, 2'd1, 32'(200 + n));
            tick;
        end
        for (int n = 0; n < 4; n++) begin
            offer(1'b1, 2'd0, 32'(300 + n));
            tick;
        end
        chk("fl_pre_id", out_id, 32'd200);
        chk("fl_pre_ch", out_ch, 2'd1);
        out_ready = 1'b1;
        flush     = 4'b0010;
        offer(1'b1, 2'd1, 32'd206);
        chk("fl_rdy", in_ready, 1'b0);
        tick;
        flush = '0;
        offer(1'b0, 2'd0, 32'd0);
        chk("fl_emp1", ch_empty[1], 1'b1);
        for (int n = 0; n < 4; n++) begin
            chk("fl_val", out_valid, 1'b1);
            chk("fl_ch", out_ch, 2'd0);
            chk("fl_id", out_id, 32'(300 + n));
            tick;
        end
        chk("fl_end", out_valid, 1'b0);
        chk("fl_emp", ch_empty, 4'b1111);

        // asynchronous reset with a packet held at the output
        out_ready = 1'b0;
        offer(1'b1, 2'd3, 32'h55);
        tick;
        offer(1'b1, 2'd3, 32'h56);
        tick;
        offer(1'b0, 2'd0, 32'd0);
        chk("ar_pre", out_valid, 1'b1);
        chk("ar_pre_emp", ch_empty, 4'b0111);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_val", out_valid, 1'b0);
        chk("ar_id", out_id, 32'd0);
        chk("ar_emp", ch_empty, 4'b1111);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("ar_post_emp", ch_empty, 4'b1111);
        chk("ar_post_full", ch_full, 4'b0000);
        chk("ar_post_id", out_id, 32'd0);
        chk("ar_post_val", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_queue_mc.md
# pkt_queue_mc

Parametrised multi-channel packet queue. It buffers id/src/dest/payload packets in NUM_CH independent per-channel circular FIFOs and delivers them through one registered output port. Channels are selected by a round-robin arbiter, and both sides use a valid/ready handshake. Each channel also has occupancy flags, an almost-full flag and a flush input. The block sits between packet producers and a single downstream consumer.

## Interface

Parameters:
- NUM_CH, 4: number of channels, ≥1; CH_W = max(1, $clog2(NUM_CH))
- DEPTH, 16: entries per channel; power of two, ≥2
- ID_W, 32: packet id width
- ADDR_W, 128: src/dest width
- PAYLOAD_W, 128: payload width
- AFULL_LVL, 14: ch_afull[c] asserts when count[c] ≥ AFULL_LVL; range 1..DEPTH

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
  - clk, in, 1: clock, rising edge
  - rst_n, in, 1: asynchronous active-low reset
- Input side:
  - in_valid, in, 1: packet offered
  - in_ready, out, 1: packet accepted this edge if in_valid
  - in_ch, in, CH_W: target channel
  - in_id / in_src / in_dest / in_payload, in, ID_W / ADDR_W / ADDR_W / PAYLOAD_W: packet fields
- Output side:
  - out_valid, out, 1: output register holds a packet
  - out_ready, in, 1: consumer takes packet this edge if out_valid
  - out_ch, out, CH_W: source channel of output packet
  - out_id / out_src / out_dest / out_payload, out, widths as input: packet fields
- Per-channel control and status:
  - flush, in, NUM_CH: per-channel synchronous flush
  - ch_empty / ch_full / ch_afull, out, NUM_CH: per-channel status from registered counts

## Operation

- **Per-channel state:**
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - count is $clog2(DEPTH)+1 bits.
  - Storage arrays are not reset.
- **Push:**
  - in_ready = in_ch < NUM_CH && !ch_full[in_ch] && !flush[in_ch].
  - in_ready is derived only from registered state and flush. A pop in the same cycle never raises it.
  - An out-of-range in_ch gives in_ready=0.
- **Load condition:** the output register loads when (!out_valid || out_ready) and at least one eligible channel exists. A channel is eligible when it is non-empty and its flush bit is low.
- **Arbiter (round-robin):**
  - Search starts at rr_ptr and proceeds upward modulo NUM_CH.
  - The first eligible channel is granted and popped. Its head entry and channel index go into the out_* registers.
  - rr_ptr ← grant+1 mod NUM_CH, updated only on a grant.
- **Output hold:** if out_valid && out_ready and nothing is eligible, out_valid clears. If out_valid && !out_ready, the out_* registers hold stable.
- **Simultaneous push and pop, same channel:** count is unchanged and both pointers advance.
- **Flush of channel c:**
  - At the edge, wr_ptr, rd_ptr and count of c go to 0.
  - A push to c in that cycle is refused (in_ready=0).
  - c is not granted in that cycle.
  - A packet already in the output register is unaffected.
- **Status flags:**
  - ch_empty = (count==0).
  - ch_full = (count==DEPTH).
  - ch_afull = (count≥AFULL_LVL).
  - All three are combinational from registered counts.

## Timing

- Reset (async assert, sync release by system):
  - out_valid=0, out_ch=0, out_id/src/dest/payload=0.
  - All counts and pointers 0, rr_ptr=0.
  - ch_empty all 1, ch_full 0, ch_afull 0.
  - in_ready is 1 for any valid in_ch.
- Reset asserted mid-operation: outputs take reset values immediately, without waiting for clk. All queued packets are lost.
- Latency: a packet accepted at edge E into an empty channel, with the output register free or draining at E+1, shows out_valid=1 after edge E+1. Minimum latency is 1 cycle.
- Throughput: one push and one pop per cycle, sustained.
- Effective capacity with out_ready=0: DEPTH+1 packets, counting the one held in the output register.
- Ordering: FIFO within a channel. Across channels, order is round-robin only.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.

## Test plan

1. **Reset:** assert rst_n=0 mid-stream with out_valid=1 -> out_valid drops before the next clk edge. After release: ch_empty=4'b1111, ch_full=0, out_id=0.
2. **Single packet:** push ch2 with id=0x11, out_ready=1 -> out_valid=1 one edge after acceptance, with out_ch=2, out_id=0x11. The next cycle out_valid=0 and ch_empty=4'b1111.
3. **Fill and drain:** with out_ready=0, push ids 0..17 to ch0.
   - 17 accepted. ch_afull[0] rises when count reaches 14 (packet id 14 accepted). ch_full[0]=1 after id 16, and id 17 sees in_ready=0.
   - Then out_ready=1 and a further 20 pushes -> ids 0..36 emerge in order, exercising pointer wrap.
4. **Round-robin:** with out_ready=0, preload ch0, ch1 and ch3 with 3 packets each. Then out_ready=1 continuously -> out_ch sequence 0,1,3,0,1,3,0,1,3, one packet per cycle.
5. **Simultaneous push/pop:** hold ch1 at count 8 and push to ch1 every cycle while the consumer takes every cycle -> count[1] stays 8 and there are no gaps in out_valid.
6. **Flush:** ch1 holds 5 packets while ch0 streams. Pulse flush=4'b0010 for one cycle together with a push to ch1 -> in_ready=0 that cycle and ch_empty[1]=1 next cycle. No ch1 packet appears afterward, and the ch0 stream is uninterrupted.
